rf_writeback: RTL



---
 rtl/frisc_pkg.sv | 25 ++
 rtl/rf_writeback_wb_fifo.sv | 60 ++++++
 rtl/rf_writeback.sv | 136 +++++++++++++
 3 files changed

// File: rtl/frisc_pkg.sv
// frisc_pkg: shared types and constants for the frisc register-file write side.
//   XLEN / NREG  : architectural data width and register count
//   reg_idx_t    : register index (clog2(NREG) bits)
//   xword_t      : one register-sized data word
//   wb_req_t     : one pending register-file write {rd, data}
package frisc_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_IDX_W = $clog2(NREG);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xword_t;

  typedef struct packed {
    reg_idx_t rd;
    xword_t   data;
  } wb_req_t;

  // x0 is hard-wired to zero; writes and reservations of it are dropped.
  function automatic logic is_real_reg(reg_idx_t r);
    return r != '0;
  endfunction

endpackage

// File: rtl/rf_writeback_wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_req_t used as the load-result queue.
//   clk, reset : clock, synchronous active-high reset (empties the queue)
//   push, din  : write din at the tail (accepted when not full, or when a pop
//                happens on the same edge)
//   pop        : drop the head entry (ignored when empty)
//   full/empty : occupancy flags
//   head       : current head entry (valid when !empty)
module wb_fifo
  import frisc_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  wb_req_t     mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    head    = mem_q[rptr_q[AW-1:0]];
    do_pop  = pop && !empty;
    // When full, the slot being written is the head being popped this edge.
    do_push = push && (!full || do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: write-side front end of the frisc register file.
// Merges single-cycle ALU results and queued load results onto the single
// register-file write port (ALU has strict priority), and keeps a pending-write
// scoreboard that decode queries for RAW hazards.
//   clk, reset               : clock, synchronous active-high reset
//   issue_valid, issue_rd    : decode reserves destination issue_rd
//   chk_rs1/2 -> busy1/2     : combinational hazard query for two sources
//   alu_valid/alu_rd/alu_data: ALU result, no backpressure
//   ld_valid/ld_rd/ld_data   : load result offered; ld_ready accepts it
//   wb_en/wb_rd/wb_data      : registered register-file write port
module rf_writeback
  import frisc_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       chk_rs1,
  input  logic [4:0]       chk_rs2,
  output logic             busy1,
  output logic             busy2,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             ld_valid,
  input  logic [4:0]       ld_rd,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data
);

  logic             alu_take;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  wb_req_t          fifo_din;
  wb_req_t          fifo_head;

  logic             sel_valid;
  logic [4:0]       sel_rd;

  logic [NREG-1:0]  pend_q, pend_d;
  logic             wb_en_q, wb_en_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;

  wb_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Load queue handshake; loads to x0 complete the handshake but are dropped.
  always_comb begin
    ld_ready  = !fifo_full && !reset;
    fifo_push = ld_valid && ld_ready && is_real_reg(ld_rd);
    fifo_din  = '{rd: ld_rd, data: ld_data};
  end

  // Port arbitration: an ALU write to x0 is discarded and does not block the
  // queue. The queue head is only popped when it is actually selected.
  always_comb begin
    alu_take  = alu_valid && is_real_reg(alu_rd);
    fifo_pop  = !reset && !alu_take && !fifo_empty;
    sel_valid = alu_take || fifo_pop;
    sel_rd    = '0;
    wb_en_d   = sel_valid;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (alu_take) begin
      sel_rd    = alu_rd;
      wb_rd_d   = alu_rd;
      wb_data_d = alu_data;
    end else if (fifo_pop) begin
      sel_rd    = fifo_head.rd;
      wb_rd_d   = fifo_head.rd;
      wb_data_d = fifo_head.data;
    end
  end

  // Scoreboard: clear on selection into wb_*, then set, so set wins on a tie.
  always_comb begin
    pend_d = pend_q;
    if (sel_valid) pend_d[sel_rd] = 1'b0;
    if (issue_valid && is_real_reg(issue_rd)) pend_d[issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= '0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      pend_q    <= pend_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // A write sitting in wb_* is not yet in the register file, so it still
  // counts as a hazard even though its pending bit has already cleared.
  always_comb begin
    busy1 = is_real_reg(chk_rs1) &&
            (pend_q[chk_rs1] || (wb_en_q && (wb_rd_q == chk_rs1)));
    busy2 = is_real_reg(chk_rs2) &&
            (pend_q[chk_rs2] || (wb_en_q && (wb_rd_q == chk_rs2)));
  end

  assign wb_en   = wb_en_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

`ifndef SYNTHESIS
  // An ALU write must never overtake a queued load to the same register.
  a_no_alu_overtake : assert property (@(posedge clk) disable iff (reset)
    !(alu_take && !fifo_empty && (fifo_head.rd == alu_rd)));
`endif

endmodule
